// File: rtl/udp_rx_machine.sv
// udp_rx_machine: receive-side Ethernet II / IPv4 / UDP parser.
// Reads the MAC byte stream and checks the destination MAC, IP and port on the fly.
// The UDP payload comes out as big-endian 32-bit words with start and end markers.
// Frames rejected in the header are discarded and counted in a saturating counter.
module udp_rx_machine #(
  parameter logic [47:0] MY_HWADDR = 48'h98_5a_eb_dd_1c_65,
  parameter logic [31:0] MY_IP     = 32'hc0a80205,
  parameter logic [15:0] MY_PORT   = 16'h4e50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_adv,
  input  logic [7:0]  rx_data,
  input  logic        rx_first,
  input  logic        rx_last,
  input  logic        rx_fcs_ok,
  output logic        rx_udp_dvld,
  output logic [31:0] rx_udp_data,
  output logic        rx_udp_sof,
  output logic [15:0] rx_udp_len,
  output logic        rx_udp_eof,
  output logic        rx_udp_ok,
  output logic [15:0] rx_drop_cnt
);

  typedef enum logic [1:0] {StIdle, StHdr, StData, StDrop} state_e;

  state_e      state_q, state_d, st_eff;
  logic [10:0] cnt_q, cnt_d;
  logic [15:0] ulen_q, ulen_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] acc_q, acc_d, acc_new;
  logic [1:0]  lane_q, lane_d;
  logic        sof_pend_q, sof_pend_d;
  logic        dvld_q, dvld_d, sof_q, sof_d, eof_q, eof_d, ok_q, ok_d;
  logic [31:0] data_q, data_d;
  logic [15:0] len_q, len_d, drop_q, drop_d;
  logic [10:0] idx;
  logic        first, hdr_bad, emit, drop_inc;

  assign first = rx_adv & rx_first;

  // Header byte checker: flags the current byte as a mismatch against its header field.
  always_comb begin
    idx     = first ? 11'd0 : cnt_q;
    hdr_bad = 1'b0;
    case (idx)
      11'd0:  hdr_bad = (rx_data != MY_HWADDR[47:40]);
      11'd1:  hdr_bad = (rx_data != MY_HWADDR[39:32]);
      11'd2:  hdr_bad = (rx_data != MY_HWADDR[31:24]);
      11'd3:  hdr_bad = (rx_data != MY_HWADDR[23:16]);
      11'd4:  hdr_bad = (rx_data != MY_HWADDR[15:8]);
      11'd5:  hdr_bad = (rx_data != MY_HWADDR[7:0]);
      11'd12: hdr_bad = (rx_data != 8'h08);
      11'd13: hdr_bad = (rx_data != 8'h00);
      11'd14: hdr_bad = (rx_data != 8'h45);
      11'd20: hdr_bad = ((rx_data & 8'h3f) != 8'h00);
      11'd21: hdr_bad = (rx_data != 8'h00);
      11'd23: hdr_bad = (rx_data != 8'h11);
      11'd30: hdr_bad = (rx_data != MY_IP[31:24]);
      11'd31: hdr_bad = (rx_data != MY_IP[23:16]);
      11'd32: hdr_bad = (rx_data != MY_IP[15:8]);
      11'd33: hdr_bad = (rx_data != MY_IP[7:0]);
      11'd36: hdr_bad = (rx_data != MY_PORT[15:8]);
      11'd37: hdr_bad = (rx_data != MY_PORT[7:0]);
      11'd39: hdr_bad = ({ulen_q[15:8], rx_data} < 16'd8);
      default: ;
    endcase
  end

  // Next-state logic: parser FSM, word assembler, output pulses and drop counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ulen_d     = ulen_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    lane_d     = lane_q;
    sof_pend_d = sof_pend_q;
    dvld_d     = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    ok_d       = 1'b0;
    data_d     = data_q;
    len_d      = len_q;
    drop_d     = drop_q;
    acc_new    = acc_q;
    emit       = 1'b0;
    drop_inc   = 1'b0;
    // A first byte in any state restarts parsing at header index 0.
    st_eff     = first ? StHdr : state_q;

    if (rx_adv) begin
      cnt_d = first ? 11'd1 : cnt_q + 11'd1;
      unique case (st_eff)
        StIdle: ;
        StHdr: begin
          state_d = StHdr;
          if (idx == 11'd38) ulen_d[15:8] = rx_data;
          if (idx == 11'd39) ulen_d[7:0] = rx_data;
          if (hdr_bad || rx_last) begin
            state_d  = rx_last ? StIdle : StDrop;
            drop_inc = 1'b1;
          end else if (idx == 11'd41) begin
            state_d    = StData;
            rem_d      = ulen_q - 16'd8;
            len_d      = ulen_q - 16'd8;
            acc_d      = '0;
            lane_d     = 2'd0;
            sof_pend_d = 1'b1;
          end
        end
        StData: begin
          // Bytes beyond the UDP length are Ethernet padding and are ignored.
          if (rem_q != 16'd0) begin
            unique case (lane_q)
              2'd0: acc_new[31:24] = rx_data;
              2'd1: acc_new[23:16] = rx_data;
              2'd2: acc_new[15:8]  = rx_data;
              2'd3: acc_new[7:0]   = rx_data;
            endcase
            rem_d  = rem_q - 16'd1;
            lane_d = lane_q + 2'd1;
            acc_d  = acc_new;
            emit   = (lane_q == 2'd3) || (rem_q == 16'd1);
          end
          // A truncated frame flushes whatever partial word is pending.
          if (rx_last && !emit && (lane_d != 2'd0)) emit = 1'b1;
          if (emit) begin
            dvld_d     = 1'b1;
            data_d     = acc_new;
            sof_d      = sof_pend_q;
            sof_pend_d = 1'b0;
            acc_d      = '0;
            lane_d     = 2'd0;
          end
          if (rx_last) begin
            state_d = StIdle;
            eof_d   = 1'b1;
            ok_d    = rx_fcs_ok && (rem_d == 16'd0);
          end
        end
        StDrop: if (rx_last) state_d = StIdle;
      endcase
    end

    if (drop_inc && (drop_q != 16'hffff)) drop_d = drop_q + 16'd1;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ulen_q     <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      lane_q     <= '0;
      sof_pend_q <= 1'b0;
      dvld_q     <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      ok_q       <= 1'b0;
      data_q     <= '0;
      len_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ulen_q     <= ulen_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      lane_q     <= lane_d;
      sof_pend_q <= sof_pend_d;
      dvld_q     <= dvld_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      ok_q       <= ok_d;
      data_q     <= data_d;
      len_q      <= len_d;
      drop_q     <= drop_d;
    end
  end

  assign rx_udp_dvld = dvld_q;
  assign rx_udp_data = data_q;
  assign rx_udp_sof  = sof_q;
  assign rx_udp_len  = len_q;
  assign rx_udp_eof  = eof_q;
  assign rx_udp_ok   = ok_q;
  assign rx_drop_cnt = drop_q;

endmodule
